// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
package uart_pkg;

  // Transmitter FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // Register word offsets from the base address.
  localparam int unsigned REG_DATA   = 0;
  localparam int unsigned REG_STATUS = 1;

  // STATUS register bit positions.
  localparam int unsigned STAT_BUSY   = 0;
  localparam int unsigned STAT_FULL   = 1;
  localparam int unsigned STAT_OVF    = 2;
  localparam int unsigned STAT_CNT_LO = 3;
  localparam int unsigned STAT_CNT_HI = 7;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// CPU data-memory bus as seen by the UART transmitter.
//
// Bus semantics: there is no valid/ready pair. The peripheral accepts every
// cycle. The address presented on a cycle is a read. When mem_we is also high
// in that cycle, it is a write as well. rd_data/rd_sel answer the address of
// the previous cycle. The CPU never stalls on this peripheral.
interface mmio_uart_tx_if;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [15:0] mem_in;
  logic [15:0] rd_data;
  logic        rd_sel;

  modport master (
    output mem_we, mem_addr, mem_in,
    input  rd_data, rd_sel
  );

  modport slave (
    input  mem_we, mem_addr, mem_in,
    output rd_data, rd_sel
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through output.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  // Storage array: written on accepted pushes, no reset needed.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: address decode, STATUS/read-data
// registers, byte FIFO and serialiser FSM.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [14:0] BASE_ADDR    = 15'h7FF0,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 16
) (
  input  logic         clk,
  input  logic         rst,
  mmio_uart_tx_if.slave bus,
  output logic         tx,
  output logic         tx_busy,
  output uart_state_t  dbg_state
);

  localparam int          BW          = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);
  localparam int          AW          = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int          CW          = AW + 1;
  localparam logic [14:0] ADDR_DATA   = BASE_ADDR + 15'(REG_DATA);
  localparam logic [14:0] ADDR_STATUS = BASE_ADDR + 15'(REG_STATUS);

  uart_state_t   r_state;
  logic [BW-1:0] r_cnt;
  logic [7:0]    r_shift;
  logic [2:0]    r_bit_idx;
  logic          r_tx;
  logic          r_ovf;
  logic [15:0]   r_rd_data;
  logic          r_rd_sel;

  logic          w_hit_data;
  logic          w_hit_status;
  logic          w_push_req;
  logic          w_pop;
  logic          w_ovf_set;
  logic          w_ovf_clr;
  logic [7:0]    w_dout;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic          w_busy;
  logic [15:0]   w_status;
  logic          w_unused_din;

  assign w_hit_data   = (bus.mem_addr == ADDR_DATA);
  assign w_hit_status = (bus.mem_addr == ADDR_STATUS);
  assign w_push_req   = bus.mem_we && w_hit_data;
  assign w_ovf_clr    = bus.mem_we && w_hit_status && bus.mem_in[STAT_OVF];
  // A full FIFO only drops the byte when nothing leaves it this cycle.
  assign w_ovf_set    = w_push_req && w_full && !w_pop;
  assign w_unused_din = ^bus.mem_in[15:8];

  // The FSM takes a byte when idle, or at the end of a stop bit for zero-gap framing.
  assign w_pop = !w_empty &&
                 ((r_state == IDLE) || ((r_state == STOP) && (r_cnt == '0)));

  assign w_busy      = !w_empty || (r_state != IDLE);
  assign tx_busy     = w_busy;
  assign tx          = r_tx;
  assign dbg_state   = r_state;
  assign bus.rd_data = r_rd_data;
  assign bus.rd_sel  = r_rd_sel;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push_req),
    .pop   (w_pop),
    .din   (bus.mem_in[7:0]),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // STATUS word assembled from the current (pre-edge) state.
  always_comb begin
    w_status                          = '0;
    w_status[STAT_BUSY]               = w_busy;
    w_status[STAT_FULL]               = w_full;
    w_status[STAT_OVF]                = r_ovf;
    w_status[STAT_CNT_HI:STAT_CNT_LO] = 5'(w_count);
  end

  // Sticky overflow flag; a new overflow beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= w_ovf_set | (r_ovf & ~w_ovf_clr);
    end
  end

  // Registered read path, one cycle behind the address, aligned with RAM data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data <= '0;
      r_rd_sel  <= 1'b0;
    end else begin
      r_rd_sel  <= w_hit_data || w_hit_status;
      r_rd_data <= w_hit_status ? w_status : 16'h0000;
    end
  end

  // Serialiser: start bit, 8 data bits LSB first, stop bit; tx comes from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_tx      <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_shift <= w_dout;
            r_cnt   <= BAUD_RELOAD;
            r_tx    <= 1'b0;
            r_state <= START;
          end
        end
        START: begin
          if (r_cnt == '0) begin
            r_cnt     <= BAUD_RELOAD;
            r_bit_idx <= '0;
            r_tx      <= r_shift[0];
            r_state   <= DATA;
          end else begin
            r_cnt <= r_cnt - BW'(1);
          end
        end
        DATA: begin
          if (r_cnt == '0) begin
            r_cnt     <= BAUD_RELOAD;
            r_shift   <= {1'b0, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= STOP;
            end else begin
              r_tx <= r_shift[1];
            end
          end else begin
            r_cnt <= r_cnt - BW'(1);
          end
        end
        STOP: begin
          if (r_cnt == '0) begin
            if (!w_empty) begin
              r_shift <= w_dout;
              r_cnt   <= BAUD_RELOAD;
              r_tx    <= 1'b0;
              r_state <= START;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt - BW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: cycle-level reference model of the line, FIFO and
// STATUS register, table-driven register vectors, and hand-written corner cases.
module tb_mmio_uart_tx;
  import uart_pkg::*;

  localparam int          CPB   = 4;
  localparam int          DEPTH = 16;
  localparam logic [14:0] BASE  = 15'h7FF0;
  localparam logic [14:0] A_DAT = 15'h7FF0;
  localparam logic [14:0] A_STA = 15'h7FF1;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx;
  logic        tx_busy;
  uart_state_t dbg_state;

  always #5 clk = ~clk;

  mmio_uart_tx_if bus_if ();

  mmio_uart_tx #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if.slave),
    .tx        (tx),
    .tx_busy   (tx_busy),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard / reference model ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  fifo_q[$];   // bytes waiting to be sent
  logic [0:0]  exp_q[$];    // expected line level after each upcoming edge
  logic        m_ovf;
  logic        m_busy;
  logic        m_exp_tx;
  logic        m_exp_busy;
  logic        m_exp_sel;
  logic [15:0] m_exp_rd;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    fifo_q.delete();
    exp_q.delete();
    m_ovf  = 1'b0;
    m_busy = 1'b0;
  endfunction

  // One clock edge of the peripheral, described by its externally visible rules.
  function automatic void model_step(input logic we, input logic [14:0] a, input logic [15:0] d);
    logic [7:0] b;
    logic       consumed;
    logic       set;
    logic       clr;
    // read path sees the state before the edge
    m_exp_sel = (a == A_DAT) || (a == A_STA);
    m_exp_rd  = 16'h0000;
    if (a == A_STA) begin
      m_exp_rd[0]   = m_busy;
      m_exp_rd[1]   = (fifo_q.size() == DEPTH);
      m_exp_rd[2]   = m_ovf;
      m_exp_rd[7:3] = 5'(fifo_q.size());
    end
    // line: a finished (or never started) frame lets the next byte go out
    if (exp_q.size() == 0 && fifo_q.size() > 0) begin
      b = fifo_q.pop_front();
      for (int i = 0; i < CPB; i++) exp_q.push_back(1'b0);
      for (int k = 0; k < 8; k++)
        for (int i = 0; i < CPB; i++) exp_q.push_back(b[k]);
      for (int i = 0; i < CPB; i++) exp_q.push_back(1'b1);
    end
    consumed = (exp_q.size() > 0);
    m_exp_tx = consumed ? exp_q.pop_front() : 1'b1;
    // writes
    set = 1'b0;
    if (we && a == A_DAT) begin
      if (fifo_q.size() < DEPTH) fifo_q.push_back(d[7:0]);
      else                       set = 1'b1;
    end
    clr        = we && (a == A_STA) && d[2];
    m_ovf      = set | (m_ovf & ~clr);
    m_busy     = (fifo_q.size() > 0) || consumed;
    m_exp_busy = m_busy;
  endfunction

  function automatic logic model_pops_next();
    return (exp_q.size() == 0) && (fifo_q.size() > 0);
  endfunction

  // ---------------- driver ----------------
  task automatic cyc(input logic we, input logic [14:0] a, input logic [15:0] d);
    bus_if.mem_we   = we;
    bus_if.mem_addr = a;
    bus_if.mem_in   = d;
    model_step(we, a, d);
    @(posedge clk);
    #1;
    check("tx",      16'(tx),            16'(m_exp_tx));
    check("tx_busy", 16'(tx_busy),       16'(m_exp_busy));
    check("rd_sel",  16'(bus_if.rd_sel), 16'(m_exp_sel));
    check("rd_data", bus_if.rd_data,     m_exp_rd);
    bus_if.mem_we = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 15'h0000, 16'h0000);
  endtask

  // ---------------- register access vectors ----------------
  typedef struct {
    logic        we;
    logic [14:0] addr;
    logic [15:0] din;
    logic        exp_sel;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs[9];

  // ---------------- test sequence ----------------
  logic        samp[40];
  logic [9:0]  frame;
  int          busy_cnt;
  int          guard;
  int          r;
  logic [14:0] ra;

  initial begin
    bus_if.mem_we   = 1'b0;
    bus_if.mem_addr = 15'h0000;
    bus_if.mem_in   = 16'h0000;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    check("reset_tx",      16'(tx),            16'h0001);
    check("reset_busy",    16'(tx_busy),       16'h0000);
    check("reset_rd_sel",  16'(bus_if.rd_sel), 16'h0000);
    check("reset_rd_data", bus_if.rd_data,     16'h0000);
    check("reset_state",   16'(dbg_state),     16'(IDLE));

    // idle line, then STATUS read
    idle(20);
    cyc(1'b0, A_STA, 16'h0000);
    check("idle_status_sel",  16'(bus_if.rd_sel), 16'h0001);
    check("idle_status_data", bus_if.rd_data,     16'h0000);

    // single frame 0x55, high byte ignored
    cyc(1'b1, A_DAT, 16'hAB55);
    for (int i = 0; i < 40; i++) begin
      idle(1);
      samp[i] = tx;
    end
    check("first_fall", 16'(samp[0]), 16'h0000);
    frame = {1'b1, 8'h55, 1'b0};
    for (int j = 0; j < 10; j++)
      for (int i = 0; i < CPB; i++)
        check($sformatf("cell%0d", j), 16'(samp[j*CPB+i]), 16'(frame[j]));
    idle(1);
    check("busy_after_frame", 16'(tx_busy), 16'h0000);

    // back-to-back frames with no gap
    cyc(1'b1, A_DAT, 16'h0001);
    cyc(1'b1, A_DAT, 16'h0080);
    busy_cnt = 0;
    for (int i = 0; i < 85; i++) begin
      idle(1);
      if (tx_busy) busy_cnt++;
    end
    check("b2b_busy_cycles", 16'(busy_cnt), 16'd79);

    // overflow: 18 writes while idle
    for (int i = 0; i < 18; i++) cyc(1'b1, A_DAT, 16'(8'h10 + i));
    cyc(1'b0, A_STA, 16'h0000);
    check("ovf_status", bus_if.rd_data, 16'h0087);
    cyc(1'b1, A_STA, 16'h0004);
    cyc(1'b0, A_STA, 16'h0000);
    check("ovf_cleared", bus_if.rd_data, 16'h0083);
    guard = 0;
    while (!model_pops_next() && guard < 200) begin
      idle(1);
      guard++;
    end
    check("pop_wait_timeout", 16'(guard < 200), 16'h0001);
    cyc(1'b1, A_DAT, 16'h005A);
    cyc(1'b0, A_STA, 16'h0000);
    check("push_pop_full", bus_if.rd_data, 16'h0083);
    guard = 0;
    while ((m_busy || tx_busy) && guard < 1200) begin
      idle(1);
      guard++;
    end
    check("drain_timeout", 16'(guard < 1200), 16'h0001);
    check("drained_busy", 16'(tx_busy), 16'h0000);

    // reset in the middle of a frame
    cyc(1'b1, A_DAT, 16'h00C3);
    idle(14);
    check("pre_reset_busy", 16'(tx_busy), 16'h0001);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_tx",   16'(tx),      16'h0001);
    check("async_rst_busy", 16'(tx_busy), 16'h0000);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1'b0, A_STA, 16'h0000);
    check("post_rst_status", bus_if.rd_data, 16'h0000);
    idle(50);

    // table-driven register vectors
    vecs[0] = '{1'b0, 15'h7FF1, 16'h0000, 1'b1, 16'h0000};
    vecs[1] = '{1'b0, 15'h7FF0, 16'h0000, 1'b1, 16'h0000};
    vecs[2] = '{1'b0, 15'h7FEF, 16'h0000, 1'b0, 16'h0000};
    vecs[3] = '{1'b0, 15'h7FF2, 16'h0000, 1'b0, 16'h0000};
    vecs[4] = '{1'b1, 15'h7FEF, 16'h00AA, 1'b0, 16'h0000};
    vecs[5] = '{1'b1, 15'h7FF2, 16'h00BB, 1'b0, 16'h0000};
    vecs[6] = '{1'b0, 15'h7FF1, 16'h0000, 1'b1, 16'h0000};
    vecs[7] = '{1'b1, 15'h7FF1, 16'h0004, 1'b1, 16'h0000};
    vecs[8] = '{1'b0, 15'h7FF1, 16'h0000, 1'b1, 16'h0000};
    for (int v = 0; v < 9; v++) begin
      cyc(vecs[v].we, vecs[v].addr, vecs[v].din);
      check($sformatf("vec%0d_sel", v),  16'(bus_if.rd_sel), 16'(vecs[v].exp_sel));
      check($sformatf("vec%0d_data", v), bus_if.rd_data,     vecs[v].exp_data);
    end

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      case ($urandom_range(0, 4))
        0:       ra = A_DAT;
        1:       ra = A_STA;
        2:       ra = 15'h7FEF;
        3:       ra = 15'h7FF2;
        default: ra = 15'($urandom);
      endcase
      if (r < 20) cyc(1'b1, A_DAT, 16'($urandom));
      else if (r < 30) cyc(1'b1, ra, 16'($urandom));
      else cyc(1'b0, ra, 16'h0000);
    end
    guard = 0;
    while ((m_busy || tx_busy) && guard < 1200) begin
      idle(1);
      guard++;
    end
    check("final_drain_timeout", 16'(guard < 1200), 16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
